// File: rtl/shared_reg_arbiter_pkg.sv
// Shared constants and FSM state encoding for the shared register arbiter.
package shared_reg_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;
  localparam int CNTW_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Request/grant/acknowledge bundle between producers and the arbiter.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF
);

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;

  modport master (output req, output wdata, input gnt, input ack);
  modport slave  (input req, input wdata, output gnt, output ack);

endinterface

// File: rtl/shared_reg_arbiter_word_register.sv
// WIDTH-bit storage register with load enable and asynchronous active-high clear.
module word_register
  import shared_reg_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that lets NREQ producers take turns writing one shared word.
//
// state | meaning
// IDLE  | no grant; arbitrate among asserted requests
// LOAD  | one requester granted; commit its data if its request is still up
// DONE  | committed and acknowledged; wait for the winner to release req
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  shared_reg_arbiter_if.slave      bus,
  output logic [WIDTH-1:0]         reg_q,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy,
  output logic [CNTW-1:0]          commit_cnt
);

  localparam int IW = $clog2(NREQ);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   win_q, win_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            load;
  logic [WIDTH-1:0] slot [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot[i] = bus.wdata[i*WIDTH +: WIDTH];
  end

  // Search starts just above the last committer, so it becomes lowest priority.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   base);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = base;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = IW'((int'(base) + i) % NREQ);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      owner_q <= IW'(NREQ - 1);
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      owner_q <= owner_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = ack_q;
    owner_d = owner_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d   = rr_pick(bus.req, owner_q);
          gnt_d   = NREQ'(1) << win_d;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (bus.req[win_q]) begin
          load    = 1'b1;
          owner_d = win_q;
          cnt_d   = cnt_q + CNTW'(1);
          ack_d   = NREQ'(1) << win_q;
          state_d = DONE;
        end else begin
          // Withdrawn before commit: owner stays put so rotation is not advanced.
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (!bus.req[win_q]) begin
          gnt_d   = '0;
          ack_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        ack_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  word_register #(.WIDTH(WIDTH)) u_word_register (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .d    (slot[win_q]),
    .q    (reg_q)
  );

  assign bus.gnt    = gnt_q;
  assign bus.ack    = ack_q;
  assign owner      = owner_q;
  assign commit_cnt = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed table, corner sequences, random traffic.
module tb_shared_reg_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] reg_q;
  logic [1:0]       owner;
  logic             busy;
  logic [CNTW-1:0]  commit_cnt;

  shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .reg_q      (reg_q),
    .owner      (owner),
    .busy       (busy),
    .commit_cnt (commit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: who holds the grant, whether it has committed, and the visible results.
  int         m_hold;
  bit         m_done;
  int         m_owner;
  int         m_cnt;
  logic [7:0] m_reg;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic [7:0] rq;
    logic [1:0] own;
    logic       bsy;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int base);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (r[i]) begin
        d = (i - base - 1 + 2 * NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    m_hold  = -1;
    m_done  = 1'b0;
    m_owner = NREQ - 1;
    m_cnt   = 0;
    m_reg   = 8'h00;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic [31:0] wd);
    if (m_hold < 0) begin
      if (r != 4'b0000) m_hold = pick(r, m_owner);
    end else if (!m_done) begin
      if (r[m_hold]) begin
        m_reg   = wd[m_hold*8 +: 8];
        m_owner = m_hold;
        m_cnt   = (m_cnt + 1) % (1 << CNTW);
        m_done  = 1'b1;
      end else begin
        m_hold = -1;
      end
    end else if (!r[m_hold]) begin
      m_hold = -1;
      m_done = 1'b0;
    end
  endtask

  task automatic check_model(input string tag);
    logic [3:0] eg;
    logic [3:0] ea;
    eg = (m_hold >= 0) ? (4'b0001 << m_hold) : 4'b0000;
    ea = (m_hold >= 0 && m_done) ? (4'b0001 << m_hold) : 4'b0000;
    chk({tag, ".gnt"},   32'(bus.gnt),    32'(eg));
    chk({tag, ".ack"},   32'(bus.ack),    32'(ea));
    chk({tag, ".reg_q"}, 32'(reg_q),      32'(m_reg));
    chk({tag, ".owner"}, 32'(owner),      32'(m_owner));
    chk({tag, ".busy"},  32'(busy),       32'(m_hold >= 0));
    chk({tag, ".cnt"},   32'(commit_cnt), 32'(m_cnt));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) model_edge(bus.req, bus.wdata);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.req   = 4'b0000;
    model_reset();
    #12;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         order[$];
    int         exp_order [5];
    int         cyc;
    logic [3:0] pg;
    logic [3:0] nreq;
    int         r;
    int         waited;

    tbl[0]  = '{4'b0100, 4'b0100, 4'b0000, 8'h00, 2'd3, 1'b1, 4'd0};
    tbl[1]  = '{4'b0100, 4'b0100, 4'b0100, 8'hC3, 2'd2, 1'b1, 4'd1};
    tbl[2]  = '{4'b0100, 4'b0100, 4'b0100, 8'hC3, 2'd2, 1'b1, 4'd1};
    tbl[3]  = '{4'b0000, 4'b0000, 4'b0000, 8'hC3, 2'd2, 1'b0, 4'd1};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 8'hC3, 2'd2, 1'b1, 4'd1};
    tbl[5]  = '{4'b0001, 4'b0001, 4'b0001, 8'h11, 2'd0, 1'b1, 4'd2};
    tbl[6]  = '{4'b1001, 4'b0001, 4'b0001, 8'h11, 2'd0, 1'b1, 4'd2};
    tbl[7]  = '{4'b1001, 4'b0001, 4'b0001, 8'h11, 2'd0, 1'b1, 4'd2};
    tbl[8]  = '{4'b1000, 4'b0000, 4'b0000, 8'h11, 2'd0, 1'b0, 4'd2};
    tbl[9]  = '{4'b1000, 4'b1000, 4'b0000, 8'h11, 2'd0, 1'b1, 4'd2};
    tbl[10] = '{4'b1000, 4'b1000, 4'b1000, 8'h44, 2'd3, 1'b1, 4'd3};
    tbl[11] = '{4'b0000, 4'b0000, 4'b0000, 8'h44, 2'd3, 1'b0, 4'd3};
    tbl[12] = '{4'b0010, 4'b0010, 4'b0000, 8'h44, 2'd3, 1'b1, 4'd3};
    tbl[13] = '{4'b0000, 4'b0000, 4'b0000, 8'h44, 2'd3, 1'b0, 4'd3};
    tbl[14] = '{4'b0011, 4'b0001, 4'b0000, 8'h44, 2'd3, 1'b1, 4'd3};
    tbl[15] = '{4'b0011, 4'b0001, 4'b0001, 8'h11, 2'd0, 1'b1, 4'd4};
    tbl[16] = '{4'b0010, 4'b0000, 4'b0000, 8'h11, 2'd0, 1'b0, 4'd4};
    tbl[17] = '{4'b0010, 4'b0010, 4'b0000, 8'h11, 2'd0, 1'b1, 4'd4};
    tbl[18] = '{4'b0010, 4'b0010, 4'b0010, 8'h22, 2'd1, 1'b1, 4'd5};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 8'h22, 2'd1, 1'b0, 4'd5};

    rst       = 1'b1;
    bus.req   = 4'b0000;
    bus.wdata = '0;
    do_reset();
    chk("rst.gnt",   32'(bus.gnt),    32'h0);
    chk("rst.ack",   32'(bus.ack),    32'h0);
    chk("rst.reg_q", 32'(reg_q),      32'h0);
    chk("rst.owner", 32'(owner),      32'd3);
    chk("rst.busy",  32'(busy),       32'h0);
    chk("rst.cnt",   32'(commit_cnt), 32'h0);

    // Directed table: single requester, contention while busy, withdrawal.
    bus.wdata = 32'h44C3_2211;
    for (int k = 0; k < 20; k++) begin
      bus.req = tbl[k].req;
      step("tbl_model");
      chk($sformatf("tbl%0d.gnt", k),   32'(bus.gnt),    32'(tbl[k].gnt));
      chk($sformatf("tbl%0d.ack", k),   32'(bus.ack),    32'(tbl[k].ack));
      chk($sformatf("tbl%0d.reg_q", k), 32'(reg_q),      32'(tbl[k].rq));
      chk($sformatf("tbl%0d.owner", k), 32'(owner),      32'(tbl[k].own));
      chk($sformatf("tbl%0d.busy", k),  32'(busy),       32'(tbl[k].bsy));
      chk($sformatf("tbl%0d.cnt", k),   32'(commit_cnt), 32'(tbl[k].cnt));
    end

    // Asynchronous reset in the middle of DONE.
    do_reset();
    bus.wdata = 32'h0000_5A00;
    bus.req   = 4'b0010;
    step("rstmid");
    step("rstmid");
    chk("rstmid.pre_reg_q", 32'(reg_q), 32'h5A);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rstmid.gnt",   32'(bus.gnt),    32'h0);
    chk("rstmid.ack",   32'(bus.ack),    32'h0);
    chk("rstmid.reg_q", 32'(reg_q),      32'h0);
    chk("rstmid.owner", 32'(owner),      32'd3);
    chk("rstmid.busy",  32'(busy),       32'h0);
    chk("rstmid.cnt",   32'(commit_cnt), 32'h0);
    bus.req = 4'b0000;
    @(negedge clk);
    rst = 1'b0;

    // Round robin with all four requesters cycling their req.
    do_reset();
    bus.wdata = 32'hA3B2_C1D0;
    bus.req   = 4'b1111;
    pg        = 4'b0000;
    cyc       = 0;
    while (order.size() < 5 && cyc < 80) begin
      step("rr");
      cyc++;
      if (bus.gnt != 4'b0000 && pg == 4'b0000) order.push_back(idx_of(bus.gnt));
      pg   = bus.gnt;
      nreq = bus.req;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) nreq[i] = 1'b0;
        else if (!bus.req[i]) nreq[i] = 1'b1;
      end
      bus.req = nreq;
    end
    exp_order = '{0, 1, 2, 3, 0};
    chk("rr.grants", 32'(order.size()), 32'd5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr.order%0d", k), (k < order.size()) ? 32'(order[k]) : 32'hFFFF_FFFF,
          32'(exp_order[k]));
    bus.req = 4'b0000;
    step("rr");
    step("rr");

    // Commit counter wrap with a 4-bit counter.
    do_reset();
    for (int c = 0; c < 17; c++) begin
      r         = c % NREQ;
      bus.wdata = $urandom;
      bus.req   = 4'b0001 << r;
      waited    = 0;
      while (!bus.ack[r] && waited < 10) begin
        step("wrap");
        waited++;
      end
      chk("wrap.ack_seen", 32'(bus.ack[r]), 32'd1);
      bus.req = 4'b0000;
      step("wrap");
      if (c == 14) chk("wrap.cnt15", 32'(commit_cnt), 32'd15);
      if (c == 15) chk("wrap.cnt16", 32'(commit_cnt), 32'd0);
    end
    chk("wrap.cnt17", 32'(commit_cnt), 32'd1);

    // Random traffic against the model, including early withdrawals.
    do_reset();
    for (int k = 0; k < 400; k++) begin
      nreq = bus.req;
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 3) == 0) nreq[i] = ~nreq[i];
      bus.req   = nreq;
      bus.wdata = $urandom;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
